// File: rtl/sram_ctrl_if.sv
// Request/response handshake bundle between a requester and sram_ctrl.
interface sram_ctrl_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    modport master (output req_valid, req_write, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_write, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/sram_ctrl.sv
// Single-word strobe sequencer for the 32x16 asynchronous SRAM macro.
// Optional write readback check is enabled by defining SRAM_CTRL_WRCHECK_EN.
module sram_ctrl #(
    parameter int DATA_W        = 16,
    parameter int ADDR_W        = 5,
    parameter int STROBE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    sram_ctrl_if.slave        bus,
    output logic [DATA_W-1:0] sram_din,
    output logic              sram_wr,
    output logic              sram_rd,
    output logic [ADDR_W-1:0] sram_addr,
    input  logic [DATA_W-1:0] sram_dout
);
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SETUP  = 3'd1,
        STROBE = 3'd2,
        GAP    = 3'd3,
        HOLD   = 3'd4
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(STROBE_CYCLES - 1);

    state_t            state_r, state_s;
    logic [3:0]        cnt_r, cnt_s;
    logic              write_r, write_s;
    logic              ready_r, ready_s;
    logic              valid_r, valid_s;
    logic              wr_r, wr_s;
    logic              rd_r, rd_s;
    logic [ADDR_W-1:0] addr_r, addr_s;
    logic [DATA_W-1:0] din_r, din_s;
    logic [DATA_W-1:0] rdata_r, rdata_s;
`ifdef SRAM_CTRL_WRCHECK_EN
    logic              verify_r, verify_s;
    logic              err_r, err_s;
`endif

    // Next state and next value of every registered output.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        write_s = write_r;
        ready_s = 1'b0;
        valid_s = 1'b0;
        wr_s    = 1'b0;
        rd_s    = 1'b0;
        addr_s  = addr_r;
        din_s   = din_r;
        rdata_s = rdata_r;
`ifdef SRAM_CTRL_WRCHECK_EN
        verify_s = verify_r;
        err_s    = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (bus.req_valid && ready_r) begin
                    state_s = SETUP;
                    write_s = bus.req_write;
                    addr_s  = bus.req_addr;
                    din_s   = bus.req_wdata;
`ifdef SRAM_CTRL_WRCHECK_EN
                    verify_s = 1'b0;
`endif
                end else begin
                    ready_s = 1'b1;
                end
            end
            SETUP: begin
                state_s = STROBE;
                cnt_s   = CNT_LOAD;
                wr_s    = write_r;
                rd_s    = !write_r;
            end
            STROBE: begin
                if (cnt_r == 4'd0) begin
`ifdef SRAM_CTRL_WRCHECK_EN
                    // A finished write strobe is followed by a gap and a readback strobe.
                    if (write_r && !verify_r) begin
                        state_s = GAP;
                    end else begin
                        state_s = HOLD;
                        valid_s = 1'b1;
                        rdata_s = sram_dout;
                        err_s   = verify_r && (sram_dout != din_r);
                    end
`else
                    state_s = HOLD;
                    valid_s = 1'b1;
                    if (!write_r) begin
                        rdata_s = sram_dout;
                    end else begin
                        rdata_s = rdata_r;
                    end
`endif
                end else begin
                    cnt_s = cnt_r - 4'd1;
                    wr_s  = wr_r;
                    rd_s  = rd_r;
                end
            end
`ifdef SRAM_CTRL_WRCHECK_EN
            GAP: begin
                state_s  = STROBE;
                cnt_s    = CNT_LOAD;
                rd_s     = 1'b1;
                verify_s = 1'b1;
            end
`endif
            HOLD: begin
                state_s = IDLE;
                ready_s = 1'b1;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the strobes asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            write_r <= 1'b0;
            ready_r <= 1'b0;
            valid_r <= 1'b0;
            wr_r    <= 1'b0;
            rd_r    <= 1'b0;
            addr_r  <= '0;
            din_r   <= '0;
            rdata_r <= '0;
`ifdef SRAM_CTRL_WRCHECK_EN
            verify_r <= 1'b0;
            err_r    <= 1'b0;
`endif
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            write_r <= write_s;
            ready_r <= ready_s;
            valid_r <= valid_s;
            wr_r    <= wr_s;
            rd_r    <= rd_s;
            addr_r  <= addr_s;
            din_r   <= din_s;
            rdata_r <= rdata_s;
`ifdef SRAM_CTRL_WRCHECK_EN
            verify_r <= verify_s;
            err_r    <= err_s;
`endif
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.rsp_valid = valid_r;
    assign bus.rsp_rdata = rdata_r;
`ifdef SRAM_CTRL_WRCHECK_EN
    assign bus.rsp_err   = err_r;
`else
    assign bus.rsp_err   = 1'b0;
`endif
    assign sram_din      = din_r;
    assign sram_wr       = wr_r;
    assign sram_rd       = rd_r;
    assign sram_addr     = addr_r;

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomized bench for sram_ctrl: a transaction-level reference model predicts
// strobe windows, response timing and data from the request stream alone.
module tb_sram_ctrl;
    localparam int DW = 16;
    localparam int AW = 5;
    localparam int SC = 2;
`ifdef SRAM_CTRL_WRCHECK_EN
    localparam bit WRCHK = 1'b1;
`else
    localparam bit WRCHK = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [DW-1:0] sram_din;
    logic [DW-1:0] sram_dout;
    logic          sram_wr;
    logic          sram_rd;
    logic [AW-1:0] sram_addr;

    sram_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

    sram_ctrl #(.DATA_W(DW), .ADDR_W(AW), .STROBE_CYCLES(SC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sram_din  (sram_din),
        .sram_wr   (sram_wr),
        .sram_rd   (sram_rd),
        .sram_addr (sram_addr),
        .sram_dout (sram_dout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM device model; bad_sram makes it return the next word on reads
    logic [DW-1:0] smem [32];
    bit            bad_sram = 1'b0;
    logic [AW-1:0] rd_addr;
    assign rd_addr   = bad_sram ? sram_addr + 5'd1 : sram_addr;
    assign sram_dout = sram_rd ? smem[rd_addr] : 16'hDEAD;
    always @(negedge clk) if (sram_wr) smem[sram_addr] <= sram_din;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    typedef struct {
        int            acc;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic [DW-1:0] rd;
        logic          err;
        int            lat;
    } txn_t;

    txn_t          pend[$];
    logic [DW-1:0] ref_mem [32];
    logic [DW-1:0] exp_rdata;
    int            n_acc = 0;
    int            n_rsp = 0;
    int            n_flushed = 0;
    logic [AW-1:0] prev_addr;
    logic [1:0]    prev_stb;

    // Reference monitor: sampled on the falling edge, away from the active edge
    always @(negedge clk) begin : mon
        txn_t t;
        txn_t nt;
        int   rel;
        logic ewr, erd, ehold;
        if (!rst_n) begin
            check_eq("reset_outputs",
                     {bus.req_ready, bus.rsp_valid, bus.rsp_err, sram_wr, sram_rd,
                      sram_addr, |sram_din, |bus.rsp_rdata}, 32'd0);
            pend.delete();
            exp_rdata = '0;
            prev_addr = '0;
            prev_stb  = 2'b00;
        end else begin
            check_eq("no_overlap", {31'd0, sram_wr & sram_rd}, 32'd0);
            if (sram_addr != prev_addr) check_eq("addr_vs_strobe", {30'd0, sram_wr, sram_rd}, {30'd0, prev_stb});
            if (pend.size() == 0) begin
                check_eq("idle_ctrl", {sram_wr, sram_rd, bus.rsp_valid, bus.req_ready, bus.rsp_err}, 32'b00010);
            end else begin
                t     = pend[0];
                rel   = cyc - t.acc + 1;
                ewr   = t.w && rel >= 2 && rel <= SC + 1;
                erd   = (!t.w && rel >= 2 && rel <= SC + 1) ||
                        (t.w && WRCHK && rel >= SC + 3 && rel <= 2 * SC + 2);
                ehold = (rel == t.lat);
                check_eq("seq", {sram_wr, sram_rd, bus.rsp_valid, bus.req_ready, bus.rsp_err},
                         {27'd0, ewr, erd, ehold, 1'b0, ehold && t.err});
                check_eq("addr", {27'd0, sram_addr}, {27'd0, t.a});
                if (t.w) check_eq("din", {16'd0, sram_din}, {16'd0, t.d});
                if (rel >= t.lat) begin
                    if (!t.w || WRCHK) exp_rdata = t.rd;
                    n_rsp++;
                    void'(pend.pop_front());
                end
            end
            check_eq("rdata", {16'd0, bus.rsp_rdata}, {16'd0, exp_rdata});
            if (bus.req_valid && bus.req_ready) begin
                nt.acc = cyc + 1;
                nt.w   = bus.req_write;
                nt.a   = bus.req_addr;
                nt.d   = bus.req_wdata;
                if (nt.w) ref_mem[nt.a] = nt.d;
                nt.rd  = bad_sram ? ref_mem[5'(nt.a + 5'd1)] : ref_mem[nt.a];
                nt.err = WRCHK && nt.w && (nt.rd != nt.d);
                nt.lat = (nt.w && WRCHK) ? 2 * SC + 3 : SC + 2;
                pend.push_back(nt);
                n_acc++;
            end
            prev_addr = sram_addr;
            prev_stb  = {sram_wr, sram_rd};
        end
    end

    task automatic send(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d, output int acc);
        int n = 0;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_addr  = a;
        bus.req_wdata = d;
        acc = -1;
        while (acc < 0 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.req_ready) acc = cyc + 1;
        end
        if (acc < 0) check_eq("accept_timeout", {31'd0, bus.req_ready}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bus.req_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        bus.req_valid = 1'b0;
        while (pend.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check_eq("drain", pend.size(), 32'd0);
    endtask

    localparam int WR_GAP = SC + 3 + (WRCHK ? SC + 1 : 0);

    initial begin
        int a0, a1, k;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        for (int i = 0; i < 32; i++) begin
            smem[i]    = '0;
            ref_mem[i] = '0;
        end

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        #1 check_eq("ready_before_edge", {31'd0, bus.req_ready}, 32'd0);
        @(posedge clk);
        #1 check_eq("ready_after_rst", {31'd0, bus.req_ready}, 32'd1);

        // write then read of address 5 with valid held across both
        send(1'b1, 5'd5, 16'hA5C3, a0);
        send(1'b0, 5'd5, 16'h0000, a1);
        check_eq("wr_rd_spacing", a1 - a0, WR_GAP);
        idle(1);

        // address boundaries
        send(1'b1, 5'd0,  16'h0001, a0);
        send(1'b1, 5'd31, 16'h8000, a0);
        send(1'b0, 5'd0,  16'h0000, a0);
        send(1'b0, 5'd31, 16'h0000, a0);
        drain();

        // four back-to-back writes with req_valid held
        send(1'b1, 5'd10, 16'h1111, a0);
        for (int i = 1; i < 4; i++) begin
            send(1'b1, 5'(10 + i), 16'(16'h1111 * (i + 1)), a1);
            check_eq("b2b_spacing", a1 - a0, WR_GAP);
            a0 = a1;
        end
        drain();

        // reset during the first write strobe
        send(1'b1, 5'd7, 16'h7777, a0);
        bus.req_valid = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!sram_wr && k < 10);
        check_eq("strobe_seen", {31'd0, sram_wr}, 32'd1);
        n_flushed += pend.size();
        #2 rst_n = 1'b0;
        #1 check_eq("rst_drop_wr", {30'd0, sram_wr, bus.rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(1'b1, 5'd8, 16'h0BEE, a0);
        send(1'b0, 5'd8, 16'h0000, a0);
        send(1'b1, 5'd7, 16'h7070, a0);
        drain();

`ifdef SRAM_CTRL_WRCHECK_EN
        send(1'b1, 5'd3, 16'h1234, a0);
        send(1'b1, 5'd4, 16'hFFFF, a0);
        drain();
        bad_sram = 1'b1;
        send(1'b1, 5'd3, 16'h1234, a0);
        drain();
        bad_sram = 1'b0;
`endif

        // randomized traffic
        for (int i = 0; i < 60; i++) begin
            send(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 16'($urandom), a0);
            if ($urandom_range(0, 1) == 1) idle($urandom_range(0, 3));
        end
        drain();
        idle(3);

        check_eq("txn_count", n_rsp, n_acc - n_flushed);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
